// File: rtl/robinho_pkg.sv
// Shared definitions for the robinho robot controller slice: robot state
// codes, claw command codes, default clock rate, status-vector width,
// the status uplink FSM encoding and a byte parity helper.
package robinho_pkg;

  localparam int CLK_HZ_DEF = 50_000_000;
  localparam int STATUS_W   = 7;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_STOP    = 3'd1,
    ST_FORWARD = 3'd2,
    ST_TURN    = 3'd3,
    ST_CLAWD   = 3'd4,
    ST_CLAWU   = 3'd5
  } robot_state_t;

  typedef enum logic [1:0] {
    C_UP   = 2'd0,
    C_DOWN = 2'd1,
    C_STOP = 2'd2
  } claw_cmd_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Even parity bit over one UART payload byte.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the status uplink. Counts 0..BAUD_DIV-1 and raises a
// registered one-cycle tick during the last cycle of each bit period.
// restart holds the count at zero so the next period begins cleanly.
// BAUD_DIV must be at least 2.
module uart_baud_tick #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             tick_r;

  // Next count: hold at zero on restart, otherwise wrap at the period end.
  always_comb begin
    cnt_next_s = cnt_r;
    if (restart) begin
      cnt_next_s = '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_next_s = '0;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Counter and tick registers; tick is high exactly when the count sits at the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= (!restart) && (cnt_next_s == CNT_LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/robot_status_tx.sv
// FPGA-to-Pi status uplink. Sends {state_code, claw_dir, obj_in_sight,
// obj_is_close, seq} as a UART frame on status change, heartbeat timeout or
// explicit request. Triggers seen while a frame is in flight are coalesced
// into one follow-up frame carrying the status current at the end of the stop bit.
// Build option: define ROBOT_STATUS_PARITY_EN to append an even parity bit
// (8E1, 11 bit times); otherwise frames are 8N1 (10 bit times).
module robot_status_tx
  import robinho_pkg::*;
#(
  parameter int CLK_HZ           = CLK_HZ_DEF,
  parameter int BAUD             = 115200,
  parameter int HEARTBEAT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state_code,
  input  logic [1:0]  claw_dir,
  input  logic        obj_in_sight,
  input  logic        obj_is_close,
  input  logic        send_req,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HB_W     = $clog2(HEARTBEAT_CYCLES + 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [HB_W-1:0] HB_ONE  = HB_W'(1);

  logic [STATUS_W-1:0] status_s;
  logic [STATUS_W-1:0] last_sent_r;
  tx_state_t           state_r;
  tx_state_t           state_next_s;
  logic [2:0]          bit_idx_r;
  logic [2:0]          bit_idx_next_s;
  logic [7:0]          frame_byte_r;
  logic [HB_W-1:0]     hb_cnt_r;
  logic [15:0]         frames_r;
  logic                first_r;
  logic                pending_r;
  logic                seq_r;
  logic                tx_r;
  logic                busy_r;
  logic                tx_next_s;
  logic                busy_next_s;
  logic                tick_s;
  logic                restart_s;
  logic                trig_s;
  logic                start_frame_s;
  logic                frame_done_s;
  logic                seq_next_s;

  assign status_s      = {state_code, claw_dir, obj_in_sight, obj_is_close};
  assign trig_s        = first_r | (status_s != last_sent_r) | send_req | (hb_cnt_r == HB_LAST);
  assign restart_s     = (state_r == TX_IDLE);
  assign frame_done_s  = (state_r == TX_STOP) && tick_s;
  assign start_frame_s = (state_next_s == TX_START) && (state_r != TX_START);
  assign seq_next_s    = frame_done_s ? ~seq_r : seq_r;

  uart_baud_tick #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // Shift FSM state register together with the registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= TX_IDLE;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      tx_r    <= tx_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // Next-state logic: advance one bit per tick, chain straight into a new frame if owed.
  always_comb begin
    state_next_s   = state_r;
    bit_idx_next_s = bit_idx_r;
    case (state_r)
      TX_IDLE: begin
        if (trig_s) begin
          state_next_s = TX_START;
        end else begin
          state_next_s = TX_IDLE;
        end
      end
      TX_START: begin
        if (tick_s) begin
          state_next_s   = TX_DATA;
          bit_idx_next_s = 3'd0;
        end else begin
          state_next_s = TX_START;
        end
      end
      TX_DATA: begin
        if (tick_s) begin
          if (bit_idx_r == 3'd7) begin
`ifdef ROBOT_STATUS_PARITY_EN
            state_next_s = TX_PARITY;
`else
            state_next_s = TX_STOP;
`endif
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_next_s = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (tick_s) begin
          state_next_s = TX_STOP;
        end else begin
          state_next_s = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (tick_s) begin
          if (pending_r || trig_s) begin
            state_next_s = TX_START;
          end else begin
            state_next_s = TX_IDLE;
          end
        end else begin
          state_next_s = TX_STOP;
        end
      end
      default: begin
        state_next_s = TX_IDLE;
      end
    endcase
  end

  // Output decode for the state being entered, so tx and busy change on the same edge as the state.
  always_comb begin
    tx_next_s   = 1'b1;
    busy_next_s = (state_next_s != TX_IDLE);
    case (state_next_s)
      TX_IDLE:   tx_next_s = 1'b1;
      TX_START:  tx_next_s = 1'b0;
      TX_DATA:   tx_next_s = frame_byte_r[bit_idx_next_s];
      TX_PARITY: tx_next_s = even_parity(frame_byte_r);
      TX_STOP:   tx_next_s = 1'b1;
      default:   tx_next_s = 1'b1;
    endcase
  end

  // Frame snapshot, trigger bookkeeping, heartbeat and completed-frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_r    <= 3'd0;
      frame_byte_r <= 8'd0;
      last_sent_r  <= '0;
      hb_cnt_r     <= '0;
      frames_r     <= 16'd0;
      first_r      <= 1'b1;
      pending_r    <= 1'b0;
      seq_r        <= 1'b0;
    end else begin
      bit_idx_r <= bit_idx_next_s;
      if (start_frame_s) begin
        frame_byte_r <= {status_s, seq_next_s};
        last_sent_r  <= status_s;
        first_r      <= 1'b0;
        hb_cnt_r     <= '0;
        pending_r    <= 1'b0;
      end else begin
        if (hb_cnt_r != HB_LAST) begin
          hb_cnt_r <= hb_cnt_r + HB_ONE;
        end
        if ((state_r != TX_IDLE) && trig_s) begin
          pending_r <= 1'b1;
        end
      end
      if (frame_done_s) begin
        frames_r <= frames_r + 16'd1;
        seq_r    <= ~seq_r;
      end
    end
  end

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign frames_sent = frames_r;

endmodule

// File: tb/tb_robot_status_tx.sv
// Directed scoreboard bench for robot_status_tx at CLK_HZ=1000, BAUD=100
// (10 cycles per bit), HEARTBEAT_CYCLES=500. A line monitor decodes frames
// into a queue; the main sequence pushes expected bytes and compares.
module tb_robot_status_tx;

`ifdef ROBOT_STATUS_PARITY_EN
  localparam int FRAME = 110;
`else
  localparam int FRAME = 100;
`endif

  typedef struct {
    logic [7:0] data;
    logic       start_b;
    logic       par;
    logic       stop_b;
    int         start;
  } rx_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state_code;
  logic [1:0]  claw_dir;
  logic        obj_in_sight;
  logic        obj_is_close;
  logic        send_req;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [7:0]  exp_q[$];
  rx_t         rx_q[$];

  robot_status_tx #(
    .CLK_HZ           (1000),
    .BAUD             (100),
    .HEARTBEAT_CYCLES (500)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state_code   (state_code),
    .claw_dir     (claw_dir),
    .obj_in_sight (obj_in_sight),
    .obj_is_close (obj_is_close),
    .send_req     (send_req),
    .tx           (tx),
    .busy         (busy),
    .frames_sent  (frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  // Expected byte from the bench's current inputs and the model's sequence bit.
  function automatic logic [7:0] mk(input logic s);
    return {state_code, claw_dir, obj_in_sight, obj_is_close, s};
  endfunction

  task automatic mon_wait(input int n, inout logic abort);
    for (int k = 0; k < n && !abort; k++) begin
      @(negedge clk);
      if (rst === 1'b1) abort = 1'b1;
    end
  endtask

  // Line monitor: samples mid-bit on falling edges, drops frames cut by reset.
  initial begin : monitor
    rx_t  r;
    logic ab;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        ab      = 1'b0;
        r.start = cyc;
        r.par   = 1'b0;
        mon_wait(5, ab);
        r.start_b = tx;
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin
            mon_wait(10, ab);
            r.data[i] = tx;
          end
        end
`ifdef ROBOT_STATUS_PARITY_EN
        if (!ab) begin
          mon_wait(10, ab);
          r.par = tx;
        end
`endif
        if (!ab) begin
          mon_wait(10, ab);
          r.stop_b = tx;
        end
        if (!ab) mon_wait(4, ab);
        if (!ab) rx_q.push_back(r);
      end
    end
  end

  task automatic get_frame(input string tag, input int exp_start, output int got_start);
    rx_t        r;
    logic [7:0] eb;
    int         waited;
    waited    = 0;
    got_start = exp_start;
    while (rx_q.size() == 0 && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, " received"}, (rx_q.size() != 0), 1);
    if (rx_q.size() != 0) begin
      r = rx_q.pop_front();
      got_start = r.start;
      check({tag, " expected queued"}, (exp_q.size() != 0), 1);
      eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      check({tag, " start cycle"}, r.start, exp_start);
      check({tag, " byte"}, r.data, eb);
      check({tag, " start bit"}, r.start_b, 0);
      check({tag, " stop bit"}, r.stop_b, 1);
`ifdef ROBOT_STATUS_PARITY_EN
      check({tag, " parity"}, r.par, ^eb);
`endif
    end
  endtask

  initial begin
    int s1, st1, st2, st3, st4, st5, st6, st7, s8, st9, e;
    rst          = 1'b1;
    state_code   = 3'd1;
    claw_dir     = 2'd2;
    obj_in_sight = 1'b0;
    obj_is_close = 1'b0;
    send_req     = 1'b0;
    tick(3);
    check("reset tx", tx, 1);
    check("reset busy", busy, 0);
    check("reset frames_sent", frames_sent, 0);

    // First frame right after reset release.
    exp_q.push_back(mk(1'b0));
    rst = 1'b0;
    tick(1);
    s1 = cyc;
    check("first start tx", tx, 0);
    check("first start busy", busy, 1);

    // Two status changes mid-DATA coalesce into one follow-up frame.
    tick(30);
    state_code = 3'd2;
    tick(10);
    state_code = 3'd3;
    exp_q.push_back(mk(1'b1));
    get_frame("f1", s1, st1);
    get_frame("f2 coalesced", st1 + FRAME, st2);
    wait_cyc(st2 + FRAME);
    check("after f2 frames_sent", frames_sent, 2);
    check("after f2 busy", busy, 0);
    check("after f2 tx idle", tx, 1);

    // Static inputs: heartbeat frame 500 cycles after previous start.
    exp_q.push_back(mk(1'b0));
    get_frame("f3 heartbeat", st2 + 500, st3);
    wait_cyc(st3 + FRAME);
    check("after f3 frames_sent", frames_sent, 3);

    // Status change while idle, with a flag set.
    state_code   = 3'd1;
    obj_in_sight = 1'b1;
    exp_q.push_back(mk(1'b1));
    e = cyc + 1;
    get_frame("f4 change", e, st4);
    wait_cyc(st4 + FRAME);
    check("after f4 frames_sent", frames_sent, 4);
    check("after f4 busy", busy, 0);

    // send_req held: back-to-back frames with alternating seq.
    send_req = 1'b1;
    exp_q.push_back(mk(1'b0));
    exp_q.push_back(mk(1'b1));
    exp_q.push_back(mk(1'b0));
    e = cyc + 1;
    get_frame("f5 req", e, st5);
    wait_cyc(st5 + 2 * FRAME);
    send_req = 1'b0;
    get_frame("f6 req", st5 + FRAME, st6);
    get_frame("f7 req", st6 + FRAME, st7);
    wait_cyc(st7 + FRAME);
    check("after f7 frames_sent", frames_sent, 7);
    check("after f7 busy", busy, 0);

    // Reset during DATA bit 4 abandons the frame; status re-sent with seq 0.
    send_req = 1'b1;
    tick(1);
    s8 = cyc;
    send_req = 1'b0;
    check("f8 started busy", busy, 1);
    wait_cyc(s8 + 53);
    rst = 1'b1;
    tick(1);
    check("mid-frame reset tx", tx, 1);
    check("mid-frame reset busy", busy, 0);
    check("mid-frame reset frames_sent", frames_sent, 0);
    rst = 1'b0;
    exp_q.push_back(mk(1'b0));
    e = cyc + 1;
    get_frame("f9 after reset", e, st9);
    wait_cyc(st9 + FRAME);
    check("after f9 frames_sent", frames_sent, 1);
    check("no stray frames", rx_q.size(), 0);
    check("all expected consumed", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
